adder_rr_arbiter: RTL and testbench
===================================

// Module: adder_rr_arbiter
// PURPOSE
//  Shares a single adder #(WIDTH) datapath among N_REQ requesters.
//  Round-robin arbitration feeds the adder; each sum is registered in a one-entry output stage.
//  Each response is tagged with the id of the requester that issued it.
//  Sits between client blocks (valid/ready request channels) and one downstream consumer.
// PARAMETERS
//  WIDTH  4  operand/result width in bits, passed to the adder instance
//  N_REQ  4  number of requesters; legal range 2..16
//  ID_W   $clog2(N_REQ)  localparam, width of the requester id
// PORTS
//  clk         in   1            single clock, all logic on posedge
//  rst_n       in   1            synchronous, active-low reset
//  req_valid   in   N_REQ        bit i: requester i presents an operand pair
//  req_ready   out  N_REQ        bit i: requester i's pair is taken this cycle; at most one bit set
//  req_a       in   N_REQ*WIDTH  packed operand A; slice i = [i*WIDTH +: WIDTH]
//  req_b       in   N_REQ*WIDTH  packed operand B, same packing as req_a
//  rsp_valid   out  1            output register holds a result
//  rsp_ready   in   1            consumer takes the result this cycle
//  rsp_result  out  WIDTH        sum, modulo 2^WIDTH
//  rsp_carry   out  1            carry out of the sum
//  rsp_id      out  ID_W         index of the requester that produced the result
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - rsp_valid=0; rsp_result, rsp_carry and rsp_id = 0; state=EMPTY; priority pointer ptr=0.
//   - A result pending at reset is discarded. req_ready=0 while rst_n=0.
//  FSM on the output stage:
//   - EMPTY -> FULL on accept.
//   - FULL -> EMPTY on rsp_ready with no accept.
//   - FULL -> FULL on rsp_ready plus accept (back-to-back issue).
//   - FULL -> FULL (hold) on !rsp_ready.
//  can_accept = (state==EMPTY) | rsp_ready.
//  Grant (combinational):
//   - Grant the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
//   - No valid requester -> no grant.
//   - req_ready[i] = can_accept & grant[i]. req_ready may depend on req_valid.
//   - req_valid must not depend on req_ready.
//  Accept = |(req_valid & req_ready).
//   - On accept, the granted slices drive the adder.
//   - At the next posedge: rsp_result, rsp_carry <= {carry_out, result}; rsp_id <= grant index; rsp_valid <= 1.
//   - Latency: exactly 1 cycle from accept to rsp_valid.
//  Pointer update:
//   - On accept: ptr <= (grant+1) mod N_REQ. Wrap from N_REQ-1 to 0.
//   - No accept: ptr unchanged.
//  Backpressure:
//   - While rsp_valid & !rsp_ready, all rsp_* outputs stay stable and req_ready=0.
//   - Requesters hold req_valid and their operands until accepted.
//  Simultaneous drain and accept: the old result leaves and the new result loads in the same cycle.
//   - Throughput is 1 result/cycle with no bubble.
//  Fairness: a continuously valid requester is granted within N_REQ accepts.
//  No req_valid and no rsp_ready: all state holds.
// STRUCTURE
//  Package adder_arb_pkg holds:
//   - typedef enum logic {EMPTY, FULL} out_state_t.
//   - function rr_pick(req, ptr), returning grant index and a found flag.
//  Sub-module: exactly one instance of the existing adder #(.WIDTH(WIDTH)) as the shared datapath.
//  Arbiter, pointer and output register are written inline; no further sub-modules.
// TESTING (WIDTH=4, N_REQ=4 unless noted)
//  T1: req_valid=0001, a0=3, b0=5, rsp_ready=1 -> next cycle rsp_valid=1, result=8, carry=0, id=0.
//  T2: req_valid=0100, a2=F, b2=1 -> result=0, carry=1, id=2. a2=F, b2=F -> result=E, carry=1.
//  T3: req_valid=1111 held, rsp_ready=1 -> ids 0,1,2,3,0,1 on consecutive cycles; req_ready one-hot each cycle.
//  T4: backpressure while FULL, rsp_ready=0 for 3 cycles -> outputs stable, req_ready=0000.
//      Raise rsp_ready -> next grant accepted that same cycle; new rsp the following cycle.
//  T5: after a grant to req 2, req_valid=1010 -> grants 3 then 1.
//      Then req_valid=1000 only -> req 3 granted again with no idle cycle.
//  T6: reset while FULL (rsp_valid=1), rst_n=0 for 1 cycle -> rsp_valid=0, outputs=0.
//      Then req_valid=1111 -> first grant is 0.
//  Scoreboard all tests:
//   - Every accepted pair appears exactly once, in accept order, with a+b correct to WIDTH+1 bits.
//   - No rsp when no accept.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and the round-robin pick helper for the adder arbiter.
package adder_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int PICK_W  = 4;

  typedef enum logic {EMPTY, FULL} out_state_t;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // Unused upper request bits are zero. A 16-way circular scan from ptr
  // therefore visits live requesters in the same order as a mod-N_REQ scan.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [PICK_W-1:0]  ptr);
    pick_t             res;
    logic [PICK_W-1:0] pos;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      pos = ptr + PICK_W'(k);
      if (req[pos]) begin
        res.found = 1'b1;
        res.idx   = pos;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adder.sv
// Shared adder datapath: WIDTH-bit sum plus carry out.
module adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one adder among N_REQ requesters, with a
// one-entry tagged output register that drains and refills in the same cycle.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_carry,
  output logic [ID_W-1:0]        rsp_id
);

  out_state_t        r_state;
  out_state_t        w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [WIDTH-1:0]  r_result;
  logic              r_carry;
  logic [ID_W-1:0]   r_id;

  logic [MAX_REQ-1:0] w_req_ext;
  logic [PICK_W-1:0]  w_ptr_ext;
  pick_t              w_pick;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic               w_can_accept;
  logic               w_accept;
  logic [WIDTH-1:0]   w_op_a;
  logic [WIDTH-1:0]   w_op_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;

  always_comb begin
    w_req_ext               = '0;
    w_req_ext[N_REQ-1:0]    = req_valid;
    w_ptr_ext               = '0;
    w_ptr_ext[ID_W-1:0]     = r_ptr;
    w_pick                  = rr_pick(w_req_ext, w_ptr_ext);
    w_gnt_idx               = w_pick.idx[ID_W-1:0];
    w_can_accept            = (r_state == EMPTY) | rsp_ready;
    // Gating with rst_n keeps clients from handing over pairs during reset.
    w_accept                = rst_n & w_can_accept & w_pick.found;
    req_ready               = '0;
    if (w_accept) req_ready[w_gnt_idx] = 1'b1;
    w_op_a                  = req_a[int'(w_gnt_idx) * WIDTH +: WIDTH];
    w_op_b                  = req_b[int'(w_gnt_idx) * WIDTH +: WIDTH];
    w_ptr_nxt               = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = FULL;
      FULL:    if (rsp_ready && !w_accept) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  adder #(.WIDTH(WIDTH)) u_adder (
    .i_a     (w_op_a),
    .i_b     (w_op_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_ptr    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_id     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ptr    <= w_ptr_nxt;
        r_result <= w_sum;
        r_carry  <= w_carry;
        r_id     <= w_gnt_idx;
      end
    end
  end

  assign rsp_valid  = (r_state == FULL);
  assign rsp_result = r_result;
  assign rsp_carry  = r_carry;
  assign rsp_id     = r_id;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed scoreboard bench for adder_rr_arbiter (WIDTH=4, N_REQ=4).
module tb_adder_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_result;
  logic        rsp_carry;
  logic [1:0]  rsp_id;

  int checks   = 0;
  int failures = 0;
  logic [6:0] exp_q[$];   // {id, carry, result}

  always #5 clk = ~clk;

  adder_rr_arbiter #(.WIDTH(4), .N_REQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_id     (rsp_id)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock cycle: check the grant, and queue the expected response if granted.
  task automatic cyc(input string name, input logic [3:0] exp_rdy, input logic [4:0] exp_sum);
    @(negedge clk);
    chk(name, 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < 4; i++)
      if (exp_rdy[i]) exp_q.push_back({2'(i), exp_sum});
    @(posedge clk); #1;
  endtask

  // Single-cycle reset with offered work and a ready consumer.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = 4'h0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_outputs", 32'({rsp_valid, rsp_id, rsp_carry, rsp_result}), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'h0;
    req_a     = 16'h0;
    req_b     = 16'h0;
    rsp_ready = 1'b0;

    fork
      begin : monitor
        logic [6:0] e;
        forever begin
          @(negedge clk);
          if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL spurious_rsp got id=%0d sum=%0h exp=none", rsp_id, {rsp_carry, rsp_result});
            end else begin
              e = exp_q.pop_front();
              chk("rsp", 32'({rsp_id, rsp_carry, rsp_result}), 32'(e));
            end
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
      end
    join_none

    do_reset();

    // T1: single requester 0
    req_valid = 4'b0001; req_a = 16'h0003; req_b = 16'h0005; rsp_ready = 1'b1;
    cyc("t1_grant0", 4'b0001, 5'h08);
    req_valid = 4'b0000;
    cyc("t1_idle", 4'b0000, 5'h00);

    // T2: carry cases on requester 2
    req_valid = 4'b0100; req_a = 16'h0F00; req_b = 16'h0100;
    cyc("t2_carry", 4'b0100, 5'h10);
    req_b = 16'h0F00;
    cyc("t2_max", 4'b0100, 5'h1E);
    req_valid = 4'b0000;
    cyc("t2_drain", 4'b0000, 5'h00);

    do_reset();

    // T3: all requesters held valid -> rotation 0,1,2,3,0,1
    req_a = 16'h4321; req_b = 16'hCBA9; req_valid = 4'b1111; rsp_ready = 1'b1;
    cyc("t3_g0", 4'b0001, 5'h0A);
    cyc("t3_g1", 4'b0010, 5'h0C);
    cyc("t3_g2", 4'b0100, 5'h0E);
    cyc("t3_g3", 4'b1000, 5'h10);
    cyc("t3_g0b", 4'b0001, 5'h0A);
    cyc("t3_g1b", 4'b0010, 5'h0C);

    // T5: after grant to 2, 1010 -> 3 then 1; then 1000 -> 3 with no gap
    req_valid = 4'b0100;
    cyc("t5_g2", 4'b0100, 5'h0E);
    req_valid = 4'b1010;
    cyc("t5_g3", 4'b1000, 5'h10);
    cyc("t5_g1", 4'b0010, 5'h0C);
    req_valid = 4'b1000;
    cyc("t5_g3b", 4'b1000, 5'h10);
    req_valid = 4'b0000;
    cyc("t5_drain", 4'b0000, 5'h00);

    // T4: backpressure holds the output register and blocks grants
    req_a = 16'h0041; req_b = 16'h0042; req_valid = 4'b0001; rsp_ready = 1'b0;
    cyc("t4_fill", 4'b0001, 5'h03);
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_ready", 32'(req_ready), 32'h0);
      chk("t4_hold_outs", 32'({rsp_valid, rsp_id, rsp_carry, rsp_result}), 32'b1_00_0_0011);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    cyc("t4_release", 4'b0010, 5'h08);

    // T6: reset while FULL discards the pending result
    chk("t6_full_before_rst", 32'(rsp_valid), 32'h1);
    do_reset();
    req_a = 16'h4321; req_b = 16'hCBA9; req_valid = 4'b1111; rsp_ready = 1'b1;
    cyc("t6_g0", 4'b0001, 5'h0A);
    cyc("t6_g1", 4'b0010, 5'h0C);
    req_valid = 4'b0000;
    cyc("t6_drain", 4'b0000, 5'h00);
    cyc("t6_idle", 4'b0000, 5'h00);
    chk("t6_idle_valid", 32'(rsp_valid), 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
